multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: lw, sw, R-type, beq, with memory handshake.
// Define ITYPE_ALU_EN to add the EXECUTEI path for I-type ALU ops (0010011).
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        BEQ      = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_BEQ:       state_d = BEQ;
`ifdef ITYPE_ALU_EN
                    OP_I:         state_d = EXECUTEI;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
`ifdef ITYPE_ALU_EN
            EXECUTEI: state_d = ALUWB;
`endif
            default:  state_d = FETCH;
        endcase
    end

    logic op_legal;

    always_comb begin
        op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ);
`ifdef ITYPE_ALU_EN
        op_legal = op_legal || (op == OP_I);
`endif
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    // rst_n gates the FETCH strobes so nothing is written while held in reset
    always_comb begin
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = rst_n;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rst_n & mem_ready;
                PCWrite   = rst_n & mem_ready;
            end
            DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                illegal_op = ~op_legal;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
`ifdef ITYPE_ALU_EN
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
`endif
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations queued by
// the stimulus, popped and compared by a negedge monitor.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] BQ = 7'b1100011;
    localparam logic [6:0] IT = 7'b0010011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .state(state),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mreq, pcw, irw, rw, mw, adr;
        logic [1:0] res, srca, srcb, aluop, imm;
        logic [3:0] st;
        logic       done, ill;
    } rec_t;

    rec_t act;
    rec_t expq[$];
    int   tests = 0;
    int   fails = 0;

    assign act = {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state,
                  instr_done, illegal_op};

    always @(negedge clk) begin
        rec_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL cycle t=%0t st=%0d actual=%h required=%h",
                         $time, e.st, act, e);
            end
        end
    end

    function automatic bit legal(input logic [6:0] o);
        bit l;
        l = (o == LW) || (o == SW) || (o == RT) || (o == BQ);
`ifdef ITYPE_ALU_EN
        l = l || (o == IT);
`endif
        return l;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BQ) return 2'b10;
        return 2'b00;
    endfunction

    // Spec table of what each state drives
    function automatic rec_t model(input int st, input logic [6:0] o,
                                   input logic z, input logic mr);
        rec_t r;
        r = '0;
        r.st  = 4'(st);
        r.imm = imm_of(o);
        case (st)
            0: begin r.mreq = 1; r.srcb = 2; r.res = 2; r.irw = mr; r.pcw = mr; end
            1: begin r.srca = 1; r.srcb = 1; r.ill = !legal(o); end
            2: begin r.srca = 2; r.srcb = 1; end
            3: begin r.mreq = 1; r.adr = 1; end
            4: begin r.res = 1; r.rw = 1; r.done = 1; end
            5: begin r.mreq = 1; r.adr = 1; r.mw = 1; r.done = mr; end
            6: begin r.srca = 2; r.aluop = 2; end
            7: begin r.rw = 1; r.done = 1; end
            8: begin r.srca = 2; r.srcb = 1; r.aluop = 2; end
            9: begin r.srca = 2; r.aluop = 1; r.pcw = z; r.done = 1; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic rec_t reset_rec(input logic [6:0] o);
        rec_t r;
        r = '0;
        r.srcb = 2;
        r.res  = 2;
        r.imm  = imm_of(o);
        return r;
    endfunction

    task automatic cyc(input int st, input logic [6:0] o, input logic mr,
                       input int zsel);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        op        = o;
        mem_ready = mr;
        zero      = (zsel == 2) ? 1'($urandom) : 1'(zsel);
        expq.push_back(model(st, o, zero, mr));
    endtask

    task automatic run_instr(input logic [6:0] o, input int zsel,
                             input int wf, input int wm);
        int path[$];
        int w;
        case (o)
            LW:      path = '{0, 1, 2, 3, 4};
            SW:      path = '{0, 1, 2, 5};
            RT:      path = '{0, 1, 6, 7};
            BQ:      path = '{0, 1, 9};
`ifdef ITYPE_ALU_EN
            IT:      path = '{0, 1, 8, 7};
`endif
            default: path = '{0, 1};
        endcase
        foreach (path[i]) begin
            if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
                w = (path[i] == 0) ? wf : wm;
                if (w < 0) w = $urandom_range(0, 3);
                repeat (w) cyc(path[i], o, 1'b0, zsel);
                cyc(path[i], o, 1'b1, zsel);
            end else begin
                cyc(path[i], o, 1'($urandom), zsel);
            end
        end
    endtask

    task automatic hold_reset(input logic [6:0] o);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        expq.push_back(reset_rec(o));
        repeat (2) begin
            @(posedge clk);
            #1;
            expq.push_back(reset_rec(o));
        end
    endtask

    initial begin
        logic [6:0] rop;
        int         sel;
        op = SW;
        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            expq.push_back(reset_rec(op));
        end

        run_instr(LW, 2, 0, 0);
        run_instr(SW, 2, 0, 3);
        run_instr(BQ, 1, 0, 0);
        run_instr(BQ, 0, 0, 0);
        run_instr(IT, 2, 0, 0);
        run_instr(RT, 2, 0, 0);
        run_instr(RT, 2, 5, 0);
        run_instr(7'b1111111, 2, 0, 0);

        // async reset while MEMWRITE is stalled
        cyc(0, SW, 1'b1, 2);
        cyc(1, SW, 1'b1, 2);
        cyc(2, SW, 1'b1, 2);
        cyc(5, SW, 1'b0, 2);
        cyc(5, SW, 1'b0, 2);
        hold_reset(SW);
        run_instr(LW, 2, 1, 1);

        repeat (80) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = BQ;
                4: rop = IT;
                default: rop = 7'($urandom_range(0, 127));
            endcase
            run_instr(rop, 2, -1, -1);
        end

        cyc(0, LW, 1'b1, 2);
        cyc(1, LW, 1'b1, 2);
        cyc(2, LW, 1'b1, 2);
        hold_reset(LW);
        run_instr(BQ, 1, 0, 0);

        @(negedge clk);
        #1;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
